cpu_run_ctrl: RTL

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

---
 rtl/cpu_run_ctrl_pkg.sv | 34 +++
 rtl/cpu_run_ctrl_sat_counter.sv | 31 +++
 rtl/cpu_run_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared CPU package: run-control state encodings, decoder opcode constants
// and the STP opcode check used by the decoder.
package cpu_run_ctrl_pkg;

    localparam int INSTR_W = 16;
    localparam int CNT_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_PRIME  = 3'd2,
        ST_HALTED = 3'd3,
        ST_RUN    = 3'd4,
        ST_STEP   = 3'd5
    } run_state_e;

    // Opcode lives in instr[15:11]
    localparam logic [4:0] OP_NOP = 5'b00000;
    localparam logic [4:0] OP_LDI = 5'b00001;
    localparam logic [4:0] OP_ADD = 5'b00010;
    localparam logic [4:0] OP_SUB = 5'b00011;
    localparam logic [4:0] OP_AND = 5'b00100;
    localparam logic [4:0] OP_OR  = 5'b00101;
    localparam logic [4:0] OP_JMP = 5'b01000;
    localparam logic [4:0] OP_BRZ = 5'b01001;
    localparam logic [4:0] OP_LD  = 5'b10000;
    localparam logic [4:0] OP_ST  = 5'b10001;
    localparam logic [4:0] OP_STP = 5'b11111;

    function automatic logic is_stp(input logic [INSTR_W-1:0] instr);
        return instr[15:11] == OP_STP;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: image loading through instruction port 2, fetch priming,
// and halted / run / single-step sequencing with an executed-instruction count.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int PRIME_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [15:0]       load_data,
    input  logic              load_done,
    input  logic              run_req,
    input  logic              step_req,
    input  logic              halt_req,
    input  logic              stp_detect,
    output logic              imem_sel,
    output logic              imem_wen,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              pc_clr,
    output logic              cpu_en,
    output logic [2:0]        state,
    output logic [15:0]       cycle_cnt
);

    localparam int PW = (PRIME_CYCLES > 1) ? $clog2(PRIME_CYCLES) : 1;

    run_state_e        state_q, state_d;
    logic [PW-1:0]     prime_cnt_q, prime_cnt_d;
    logic              wen_q, wen_d;
    logic              sel_q, sel_d;
    logic              pc_clr_q, pc_clr_d;
    logic              cpu_en_q, cpu_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              xfer;
    logic              prime_entry;

    // A word offered together with load_done is never accepted.
    assign load_ready = (state_q == ST_LOAD) && !load_done;
    assign xfer       = load_valid && load_ready;

    always_comb begin
        state_d     = state_q;
        prime_cnt_d = prime_cnt_q;
        case (state_q)
            ST_IDLE:   if (load_valid) state_d = ST_LOAD;
            ST_LOAD:   if (load_done) state_d = ST_PRIME;
            ST_PRIME: begin
                if (prime_cnt_q == PW'(PRIME_CYCLES - 1))
                    state_d = ST_HALTED;
                else
                    prime_cnt_d = prime_cnt_q + 1'b1;
            end
            ST_HALTED: begin
                if (!halt_req) begin
                    if (load_valid)    state_d = ST_LOAD;
                    else if (step_req) state_d = ST_STEP;
                    else if (run_req)  state_d = ST_RUN;
                end
            end
            ST_RUN:    if (halt_req || stp_detect) state_d = ST_HALTED;
            ST_STEP:   state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase

        prime_entry = (state_d == ST_PRIME) && (state_q != ST_PRIME);
        if (prime_entry)
            prime_cnt_d = '0;

        // Transferred word appears on port 2 one cycle later; the loader keeps
        // the port for that cycle even though load_done already ended LOAD.
        wen_d    = xfer;
        addr_d   = xfer ? load_addr : addr_q;
        wdata_d  = xfer ? load_data : wdata_q;
        sel_d    = (state_d == ST_LOAD) || wen_d;
        pc_clr_d = prime_entry;
        cpu_en_d = (state_d == ST_RUN) || (state_d == ST_STEP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            prime_cnt_q <= '0;
            wen_q       <= 1'b0;
            sel_q       <= 1'b0;
            pc_clr_q    <= 1'b0;
            cpu_en_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            prime_cnt_q <= prime_cnt_d;
            wen_q       <= wen_d;
            sel_q       <= sel_d;
            pc_clr_q    <= pc_clr_d;
            cpu_en_q    <= cpu_en_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (prime_entry),
        .en    (cpu_en_q),
        .cnt   (cycle_cnt)
    );

    assign state      = state_q;
    assign imem_sel   = sel_q;
    assign imem_wen   = wen_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign pc_clr     = pc_clr_q;
    assign cpu_en     = cpu_en_q;

endmodule
